// File: rtl/hmem_word_server.sv
// Word-granular backing memory behind the cache's higher-memory port: one LOAD/STORE
// at a time, fixed per-operation latency, one-cycle fulfil pulse, saturating statistics.
module hmem_word_server #(
    parameter int ADDR_W        = 32,
    parameter int WORD_W        = 32,
    parameter int DEPTH_WORDS   = 1024,
    parameter int LOAD_LATENCY  = 4,
    parameter int STORE_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic [1:0]        req_operation,
    input  logic [ADDR_W-1:0] req_address,
    input  logic [WORD_W-1:0] req_store_word,
    output logic              req_fulfilled,
    output logic [WORD_W-1:0] req_loaded_word,
    output logic              busy,
    output logic              error,
    output logic [31:0]       load_count,
    output logic [31:0]       store_count
);

    localparam int IDX_W   = $clog2(DEPTH_WORDS);
    localparam int MAX_LAT = (LOAD_LATENCY > STORE_LATENCY) ? LOAD_LATENCY : STORE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_STORE = 2'd1;

    localparam logic [CNT_W-1:0] LOAD_CNT_INIT  = CNT_W'(LOAD_LATENCY - 1);
    localparam logic [CNT_W-1:0] STORE_CNT_INIT = CNT_W'(STORE_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              in_range_q, in_range_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              error_q, error_d;
    logic [31:0]       load_cnt_q, load_cnt_d;
    logic [31:0]       store_cnt_q, store_cnt_d;
    logic [WORD_W-1:0] loaded_word_q, loaded_word_d;
    logic              fulfil;
    logic              mem_we;

    logic [IDX_W-1:0]  req_idx;
    logic              req_hi_zero;
    logic              req_in_range;
    logic [IDX_W-1:0]  rd_idx;
    logic [WORD_W-1:0] rd_q;
    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    assign req_idx = req_address[IDX_W+1:2];

    generate
        if (ADDR_W > IDX_W + 2) begin : g_hi_bits
            assign req_hi_zero = (req_address[ADDR_W-1:IDX_W+2] == '0);
        end else begin : g_no_hi_bits
            assign req_hi_zero = 1'b1;
        end
    endgenerate

    assign req_in_range = req_hi_zero && (req_address[1:0] == 2'b00);

    // Read one cycle ahead of the fulfil cycle so the registered RAM output is
    // ready exactly when the pulse goes out; a latency-1 LOAD reads straight
    // from the request inputs in its accept cycle.
    assign rd_idx = (state_q == ST_IDLE) ? req_idx : idx_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= data_q;
        end
        rd_q <= mem[rd_idx];
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        idx_d         = idx_q;
        data_d        = data_q;
        in_range_d    = in_range_q;
        cnt_d         = cnt_q;
        error_d       = error_q;
        load_cnt_d    = load_cnt_q;
        store_cnt_d   = store_cnt_q;
        loaded_word_d = loaded_word_q;
        fulfil        = 1'b0;
        mem_we        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d       = req_operation;
                    idx_d      = req_idx;
                    data_d     = req_store_word;
                    in_range_d = req_in_range;
                    if (req_operation[1] || !req_in_range) begin
                        error_d = 1'b1;
                    end
                    if (req_operation == OP_LOAD) begin
                        cnt_d   = LOAD_CNT_INIT;
                        state_d = (LOAD_LATENCY == 1) ? ST_RESPOND : ST_WAIT;
                    end else begin
                        cnt_d   = STORE_CNT_INIT;
                        state_d = (STORE_LATENCY == 1) ? ST_RESPOND : ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                if (!req_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_RESPOND;
                    end
                end
            end

            ST_RESPOND: begin
                state_d = ST_IDLE;
                if (req_valid) begin
                    fulfil = 1'b1;
                    if (op_q == OP_LOAD) begin
                        loaded_word_d = in_range_q ? rd_q : '0;
                        if (in_range_q && (load_cnt_q != 32'hFFFF_FFFF)) begin
                            load_cnt_d = load_cnt_q + 32'd1;
                        end
                    end else if (op_q == OP_STORE && in_range_q) begin
                        mem_we = 1'b1;
                        if (store_cnt_q != 32'hFFFF_FFFF) begin
                            store_cnt_d = store_cnt_q + 32'd1;
                        end
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_LOAD;
            idx_q         <= '0;
            data_q        <= '0;
            in_range_q    <= 1'b0;
            cnt_q         <= '0;
            error_q       <= 1'b0;
            load_cnt_q    <= '0;
            store_cnt_q   <= '0;
            loaded_word_q <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            idx_q         <= idx_d;
            data_q        <= data_d;
            in_range_q    <= in_range_d;
            cnt_q         <= cnt_d;
            error_q       <= error_d;
            load_cnt_q    <= load_cnt_d;
            store_cnt_q   <= store_cnt_d;
            loaded_word_q <= loaded_word_d;
        end
    end

    // The pulse is gated by req_valid so an abort in the fulfil cycle suppresses it;
    // the loaded word shows the fresh value during the pulse and holds it afterwards.
    assign req_fulfilled   = fulfil;
    assign req_loaded_word = loaded_word_d;
    assign busy            = (state_q != ST_IDLE);
    assign error           = error_q;
    assign load_count      = load_cnt_q;
    assign store_count     = store_cnt_q;

endmodule
